fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_defs.sv | 13 +
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/fifo_arb_defs.sv
// Shared definitions for the FIFO write arbiter: state encoding and field widths.
package fifo_arb_defs;

  localparam int unsigned GID_W  = 3;
  localparam int unsigned BEAT_W = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from last+1 (mod NUM_REQ).
module rr_pick
  import fifo_arb_defs::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   last,
  output logic               found,
  output logic [GID_W-1:0]   index
);

  logic [GID_W:0]     start;
  logic [GID_W:0]     pos;
  logic [NUM_REQ-1:0] rot;

  // Rotate req so bit 0 corresponds to the highest-priority requester.
  always_comb begin
    start = (last >= GID_W'(NUM_REQ - 1)) ? '0 : ({1'b0, last} + (GID_W+1)'(1));
    rot   = (req >> start) | (req << (32'(NUM_REQ) - 32'(start)));
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = start + (GID_W+1)'(i);
        if (pos >= (GID_W+1)'(NUM_REQ)) pos = pos - (GID_W+1)'(NUM_REQ);
        index = GID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding a single FIFO write port from NUM_REQ requesters.
// Optional per-requester accepted-word counters are enabled with macro ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_defs::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [GID_W-1:0]              grant_id,
  output logic                          busy
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]      acc_cnt
`endif
);

  arb_state_e         state;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_nxt;
  logic [GID_W-1:0]   last_grant;
  logic               pick_found;
  logic [GID_W-1:0]   pick_index;
  logic               sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req_valid),
    .last  (last_grant),
    .found (pick_found),
    .index (pick_index)
  );

  // Mux out the grantee's valid and data.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_id == GID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Write-side handshake is combinational off the registered grant.
  always_comb begin
    busy         = (state == GRANT);
    fifo_wr_en   = busy && sel_valid && !fifo_full;
    fifo_wr_data = sel_data;
    req_ready    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready[i] = busy && (grant_id == GID_W'(i)) && !fifo_full;
    end
    beat_nxt     = beat_cnt + BEAT_W'(1);
  end

  // Arbitration / burst FSM; a full FIFO freezes the grant in place.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_grant <= GID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id   <= pick_index;
            last_grant <= pick_index;
            beat_cnt   <= '0;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (!fifo_full) begin
            if (!sel_valid) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_nxt;
              if (beat_nxt == BEAT_W'(BURST_MAX)) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Saturating per-requester accepted-word counters.
  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_stats
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
        cnt <= '0;
      end else if (fifo_wr_en && (grant_id == GID_W'(g)) && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
    assign acc_cnt[g*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule
